// File: rtl/tmds_rx_channel.sv
// Receive side of one TMDS lane: finds the 10-bit word boundary from control-token
// runs during blanking, then decodes aligned words into video data / control bits.
module tmds_rx_channel #(
    parameter int CTRL_RUN     = 16,
    parameter int SEARCH_WIN   = 1024,
    parameter int LOCK_TIMEOUT = 2048
) (
    input  logic       pixclk,
    input  logic       rst,
    input  logic [9:0] raw_in,
    output logic [7:0] vd,
    output logic [1:0] cd,
    output logic       vde,
    output logic       locked,
    output logic [3:0] offset,
    output logic [7:0] err_cnt
);

    localparam int WIN_MAX = (SEARCH_WIN > LOCK_TIMEOUT) ? SEARCH_WIN : LOCK_TIMEOUT;
    localparam int WIN_W   = $clog2(WIN_MAX);
    localparam int RUN_W   = $clog2(CTRL_RUN + 1);

    localparam logic [WIN_W-1:0] SEARCH_LAST  = WIN_W'(SEARCH_WIN - 1);
    localparam logic [WIN_W-1:0] TIMEOUT_LAST = WIN_W'(LOCK_TIMEOUT - 1);
    localparam logic [WIN_W-1:0] WIN_ONE      = WIN_W'(1);
    localparam logic [RUN_W-1:0] RUN_FULL     = RUN_W'(CTRL_RUN);
    localparam logic [RUN_W-1:0] RUN_LAST     = RUN_W'(CTRL_RUN - 1);
    localparam logic [RUN_W-1:0] RUN_ONE      = RUN_W'(1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // {is_token, cd} for a candidate word
    function automatic logic [2:0] token_lookup(input logic [9:0] w);
        logic [2:0] r;
        case (w)
            10'b1101010100: r = 3'b100;
            10'b0010101011: r = 3'b101;
            10'b0101010100: r = 3'b110;
            10'b1010101011: r = 3'b111;
            default:        r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] data_decode(input logic [9:0] w);
        logic [7:0] d;
        logic [7:0] q;
        d    = w[9] ? ~w[7:0] : w[7:0];
        q    = 8'h00;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return q;
    endfunction

    logic [9:0]       raw_prev_q;
    logic [9:0]       w_q;
    logic             tok_q;
    logic [1:0]       tok_cd_q;
    logic [7:0]       vd_q,  vd_d;
    logic [1:0]       cd_q,  cd_d;
    logic             vde_q, vde_d;
    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [3:0]       offset_q, offset_d;
    logic             locked_q, locked_d;
    logic [7:0]       err_q, err_d;

    logic [19:0]      cat_s;
    logic [9:0]       word_s;
    logic [2:0]       tok_info_s;
    logic             valid_run_s;
    logic             slip_s;

    // Bit 0 of raw_prev is the earliest bit, so offset k starts k bits into the older word
    assign cat_s       = {raw_in, raw_prev_q};
    assign word_s      = 10'(cat_s >> offset_q);
    assign tok_info_s  = token_lookup(word_s);
    assign valid_run_s = tok_info_s[2] && (run_q == RUN_LAST);

    // Alignment FSM next state; a valid run always overrides a pending slip
    always_comb begin
        state_d  = state_q;
        win_d    = win_q + WIN_ONE;
        offset_d = offset_q;
        locked_d = locked_q;
        err_d    = err_q;
        slip_s   = 1'b0;
        if (!tok_info_s[2]) begin
            run_d = '0;
        end else if (run_q == RUN_FULL) begin
            run_d = run_q;
        end else begin
            run_d = run_q + RUN_ONE;
        end

        case (state_q)
            ST_SEARCH: begin
                if (valid_run_s) begin
                    state_d = ST_VERIFY;
                    win_d   = '0;
                end else if (win_q == SEARCH_LAST) begin
                    slip_s = 1'b1;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_VERIFY: begin
                if (valid_run_s) begin
                    state_d  = ST_LOCKED;
                    locked_d = 1'b1;
                    win_d    = '0;
                end else if (win_q == TIMEOUT_LAST) begin
                    state_d = ST_SEARCH;
                    slip_s  = 1'b1;
                end else begin
                    state_d = ST_VERIFY;
                end
            end
            ST_LOCKED: begin
                if (valid_run_s) begin
                    win_d = '0;
                end else if (win_q == TIMEOUT_LAST) begin
                    state_d  = ST_SEARCH;
                    locked_d = 1'b0;
                    slip_s   = 1'b1;
                    err_d    = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            default: begin
                state_d  = ST_SEARCH;
                win_d    = '0;
                locked_d = 1'b0;
            end
        endcase

        if (slip_s) begin
            offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            win_d    = '0;
            run_d    = '0;
        end else begin
            offset_d = offset_d;
        end
    end

    // Output stage: gated by locked_q, which lines up with the word now in stage 1
    always_comb begin
        vd_d  = 8'h00;
        cd_d  = cd_q;
        vde_d = 1'b0;
        if (!locked_q) begin
            cd_d = 2'b00;
        end else if (tok_q) begin
            cd_d = tok_cd_q;
        end else begin
            vde_d = 1'b1;
            vd_d  = data_decode(w_q);
        end
    end

    // Pipeline and FSM registers
    always_ff @(posedge pixclk) begin
        if (rst) begin
            raw_prev_q <= 10'd0;
            w_q        <= 10'd0;
            tok_q      <= 1'b0;
            tok_cd_q   <= 2'b00;
            vd_q       <= 8'h00;
            cd_q       <= 2'b00;
            vde_q      <= 1'b0;
            state_q    <= ST_SEARCH;
            win_q      <= '0;
            run_q      <= '0;
            offset_q   <= 4'd0;
            locked_q   <= 1'b0;
            err_q      <= 8'h00;
        end else begin
            raw_prev_q <= raw_in;
            w_q        <= word_s;
            tok_q      <= tok_info_s[2];
            tok_cd_q   <= tok_info_s[1:0];
            vd_q       <= vd_d;
            cd_q       <= cd_d;
            vde_q      <= vde_d;
            state_q    <= state_d;
            win_q      <= win_d;
            run_q      <= run_d;
            offset_q   <= offset_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
        end
    end

    assign vd      = vd_q;
    assign cd      = cd_q;
    assign vde     = vde_q;
    assign locked  = locked_q;
    assign offset  = offset_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_tmds_rx_channel.sv
// Directed bench for tmds_rx_channel: decode/token table at offset 0, then a
// 640x480 blue-lane stream shifted by 3 bits for alignment, lock loss, wrap and reset.
module tb_tmds_rx_channel;

    logic       pixclk = 1'b0;
    logic       rst;
    logic [9:0] raw_in;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
    logic       locked;
    logic [3:0] offset;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    tmds_rx_channel dut (
        .pixclk (pixclk),
        .rst    (rst),
        .raw_in (raw_in),
        .vd     (vd),
        .cd     (cd),
        .vde    (vde),
        .locked (locked),
        .offset (offset),
        .err_cnt(err_cnt)
    );

    always #5 pixclk = ~pixclk;

    typedef struct {
        logic [9:0] raw;
        logic       e_vde;
        logic [7:0] e_vd;
        logic [1:0] e_cd;
    } vec_t;

    vec_t tab [12];

    // stream generator state
    int         sx, sy, disp;
    logic [9:0] prev_e;
    logic       h_v [3];
    logic [7:0] h_d [3];
    logic [1:0] h_c [3];
    logic       lk_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic [9:0] r);
        raw_in = r;
        @(posedge pixclk);
        #1;
    endtask

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = 10'b1101010100;
            2'b01:   t = 10'b0010101011;
            2'b10:   t = 10'b0101010100;
            default: t = 10'b1010101011;
        endcase
        return t;
    endfunction

    // DVI data-period encoder with running disparity
    task automatic enc(input logic [7:0] d, output logic [9:0] q);
        logic [8:0] qm;
        int n1d, n1, n0, m8;
        n1d = $countones(d);
        qm  = 9'd0;
        qm[0] = d[0];
        if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        m8 = qm[8] ? 1 : 0;
        if (disp == 0 || n1 == n0) begin
            q    = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            disp = disp + (qm[8] ? (n1 - n0) : (n0 - n1));
        end else if ((disp > 0 && n1 > n0) || (disp < 0 && n0 > n1)) begin
            q    = {1'b1, qm[8], ~qm[7:0]};
            disp = disp + 2 * m8 + (n0 - n1);
        end else begin
            q    = {1'b0, qm[8], qm[7:0]};
            disp = disp - 2 * (1 - m8) + (n1 - n0);
        end
    endtask

    task automatic next_word(output logic [9:0] e, output logic ev,
                             output logic [7:0] evd, output logic [1:0] ecd);
        logic hs;
        hs = (sx >= 656) && (sx < 752);
        if (sx < 640) begin
            ev  = 1'b1;
            evd = 8'((sx * 7) + (sy * 29));
            ecd = 2'b00;
            enc(evd, e);
        end else begin
            ev   = 1'b0;
            evd  = 8'h00;
            ecd  = {1'b0, hs};
            e    = ctrl_token(ecd);
            disp = 0;
        end
        sx++;
        if (sx == 800) begin
            sx = 0;
            sy++;
        end
    endtask

    task automatic stream_start();
        sx = 0; sy = 0; disp = 0; prev_e = 10'd0;
        for (int i = 0; i < 3; i++) begin
            h_v[i] = 1'b0; h_d[i] = 8'h00; h_c[i] = 2'b00;
        end
        lk_prev = locked;
    endtask

    // One stream word on the wire 3 bits late; output after edge n reflects word n-2
    task automatic stream_tick();
        logic [9:0] e;
        logic       ev;
        logic [7:0] evd;
        logic [1:0] ecd;
        next_word(e, ev, evd, ecd);
        tick({e[6:0], prev_e[9:7]});
        prev_e = e;
        h_v[2] = h_v[1]; h_d[2] = h_d[1]; h_c[2] = h_c[1];
        h_v[1] = h_v[0]; h_d[1] = h_d[0]; h_c[1] = h_c[0];
        h_v[0] = ev;     h_d[0] = evd;    h_c[0] = ecd;
        if (lk_prev) begin
            check("strm_vde", vde, h_v[2]);
            if (h_v[2]) check("strm_vd", vd, h_d[2]);
            else        check("strm_cd", cd, h_c[2]);
        end else begin
            check("strm_gated", {vde, vd, cd}, 32'd0);
        end
        lk_prev = locked;
    endtask

    initial begin
        int         got;
        int         cnt;
        int         n9;
        logic [3:0] last_off;

        tab[0]  = '{10'b0100000000, 1'b1, 8'h00, 2'b00};
        tab[1]  = '{10'b1000000000, 1'b1, 8'hFF, 2'b00};
        tab[2]  = '{10'b0100000001, 1'b1, 8'h03, 2'b00};
        tab[3]  = '{10'b0011111111, 1'b1, 8'hFF, 2'b00};
        tab[4]  = '{10'b1100000000, 1'b1, 8'h01, 2'b00};
        tab[5]  = '{10'b0110101010, 1'b1, 8'hFE, 2'b00};
        tab[6]  = '{10'b1101010100, 1'b0, 8'h00, 2'b00};
        tab[7]  = '{10'b0010101011, 1'b0, 8'h00, 2'b01};
        tab[8]  = '{10'b0101010100, 1'b0, 8'h00, 2'b10};
        tab[9]  = '{10'b1010101011, 1'b0, 8'h00, 2'b11};
        tab[10] = '{10'b0100000001, 1'b1, 8'h03, 2'b11};
        tab[11] = '{10'b1000000000, 1'b1, 8'hFF, 2'b11};

        rst    = 1'b1;
        raw_in = 10'd0;
        tick(10'd0);
        tick(10'd0);
        rst = 1'b0;
        check("rst_vd", vd, 32'd0);
        check("rst_cd", cd, 32'd0);
        check("rst_vde", vde, 32'd0);
        check("rst_locked", locked, 32'd0);
        check("rst_offset", offset, 32'd0);
        check("rst_err", err_cnt, 32'd0);

        // Lock at offset 0: token run, data gap, second token run
        for (int i = 0; i < 20; i++) tick(10'b1101010100);
        check("verify_not_locked", locked, 32'd0);
        for (int i = 0; i < 3; i++) tick(10'b0100000000);
        for (int i = 0; i < 20; i++) tick(10'b1101010100);
        check("hand_locked", locked, 32'd1);
        check("hand_offset", offset, 32'd0);

        for (int i = 0; i < 14; i++) begin
            tick((i < 12) ? tab[i].raw : 10'b0100000000);
            if (i >= 2) begin
                check("tab_vde", vde, tab[i-2].e_vde);
                check("tab_vd", vd, tab[i-2].e_vd);
                check("tab_cd", cd, tab[i-2].e_cd);
            end
        end

        // Alignment from reset on a stream shifted by 3 bits
        rst = 1'b1;
        tick(10'd0);
        rst = 1'b0;
        stream_start();
        got = 0;
        for (int n = 0; n < 3 * 1024 + 2 * 800 + 40 && got == 0; n++) begin
            stream_tick();
            if (locked === 1'b1) got = 1;
        end
        check("align_found", got, 32'd1);
        check("align_offset", offset, 32'd3);

        // Lock loss: no tokens after the lock edge
        cnt = 1;
        for (int n = 0; n < 2100; n++) begin
            tick(10'd0);
            if (locked === 1'b1) cnt++;
            else break;
        end
        check("loss_hold_words", cnt, 32'd2048);
        check("loss_locked", locked, 32'd0);
        check("loss_err", err_cnt, 32'd1);
        check("loss_offset", offset, 32'd4);

        // Relock on resumed stream, wrapping 9 -> 0 on the way
        stream_start();
        got      = 0;
        n9       = 0;
        last_off = offset;
        for (int n = 0; n < 9 * 1024 + 2 * 800 + 40 && got == 0; n++) begin
            stream_tick();
            if (last_off == 4'd9 && offset != 4'd9) check("wrap_to_0", offset, 32'd0);
            if (offset == 4'd9) n9++;
            last_off = offset;
            if (locked === 1'b1) got = 1;
        end
        check("relock_found", got, 32'd1);
        check("relock_offset", offset, 32'd3);
        check("wrap_win_words", n9, 32'd1024);
        check("wrap_err_same", err_cnt, 32'd1);
        for (int n = 0; n < 900; n++) stream_tick();
        check("relock_held", locked, 32'd1);

        // Single-cycle reset while locked with a nonzero error count
        rst = 1'b1;
        tick(10'd0);
        rst = 1'b0;
        check("mid_rst_vd", vd, 32'd0);
        check("mid_rst_cd", cd, 32'd0);
        check("mid_rst_vde", vde, 32'd0);
        check("mid_rst_locked", locked, 32'd0);
        check("mid_rst_offset", offset, 32'd0);
        check("mid_rst_err", err_cnt, 32'd0);
        for (int n = 0; n < 1023; n++) tick(10'd0);
        check("search_no_early_slip", offset, 32'd0);
        tick(10'd0);
        check("search_slip", offset, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
